// File: rtl/core_pkg.sv
// Shared core definitions for the write-back path.
// Holds the datapath widths, the write-back FIFO depth and the entry
// struct carried through the FIFO ({rd, data}).
package core_pkg;

  localparam int XLEN          = 32;
  localparam int REG_ADDR_W    = 5;
  localparam int WB_FIFO_DEPTH = 2;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of the write-back arbiter's bus signals.
// Handshake: the ALU result is accepted unconditionally whenever aluValid=1.
// A long-latency result transfers on a rising edge where lsuValid && lsuReady;
// the producer holds lsuRd/lsuData stable while lsuValid=1 and lsuReady=0.
// Modports:
//   slave  - the arbiter: takes results/issue/hazard queries, drives lsuReady,
//            rs1Busy/rs2Busy and the registered register-file write port.
//   master - the environment driving results and issue information.
interface wb_arbiter_if;
  import core_pkg::*;

  logic                  aluValid;
  logic [REG_ADDR_W-1:0] aluRd;
  logic [XLEN-1:0]       aluData;

  logic                  lsuValid;
  logic                  lsuReady;
  logic [REG_ADDR_W-1:0] lsuRd;
  logic [XLEN-1:0]       lsuData;

  logic                  issueValid;
  logic                  issueLong;
  logic [REG_ADDR_W-1:0] issueRd;

  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic                  rs1Busy;
  logic                  rs2Busy;

  logic                  rdWriteEn;
  logic [REG_ADDR_W-1:0] rd;
  logic [XLEN-1:0]       rdData;

  modport slave (
    input  aluValid, aluRd, aluData,
    input  lsuValid, lsuRd, lsuData,
    output lsuReady,
    input  issueValid, issueLong, issueRd,
    input  rs1, rs2,
    output rs1Busy, rs2Busy,
    output rdWriteEn, rd, rdData
  );

  modport master (
    output aluValid, aluRd, aluData,
    output lsuValid, lsuRd, lsuData,
    input  lsuReady,
    output issueValid, issueLong, issueRd,
    output rs1, rs2,
    input  rs1Busy, rs2Busy,
    input  rdWriteEn, rd, rdData
  );

endinterface

// File: rtl/wb_fifo.sv
// Two-entry FIFO buffering long-latency write-back results.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   push        - write push_entry at the tail (ignored when full)
//   push_entry  - entry to enqueue
//   pop         - drop the head entry (ignored when empty)
//   full, empty - occupancy flags from the registered count
//   head        - current head entry (valid when !empty)
//   count       - current occupancy 0..2, exposed for observation
// Flags come from the registered count only, so an entry pushed this cycle is
// never visible to a same-cycle pop (no bypass).
module wb_fifo
  import core_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head,
  output logic [1:0] count
);

  wb_entry_t  mem_q [WB_FIFO_DEPTH];
  wb_entry_t  mem_d [WB_FIFO_DEPTH];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  assign full  = (count_q == 2'(WB_FIFO_DEPTH));
  assign empty = (count_q == 2'd0);
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges single-cycle ALU results and buffered
// long-latency results onto one registered register-file write port, and
// tracks which registers still await a long-latency write.
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   bus      - wb_arbiter_if.slave: ALU/LSU results, issue info, hazard
//              queries, registered write port (rdWriteEn/rd/rdData)
// The ALU always wins; the FIFO head drains only in ALU-free cycles.
// Destination x0 results are consumed without a write and leave rd/rdData
// holding their previous values.
module wb_arbiter
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  wb_arbiter_if.slave     bus
);

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  wb_entry_t             fifo_in, fifo_head;
  logic [1:0]            fifo_count;

  logic                  sel_valid;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]       sel_data;

  logic                  rd_write_en_q, rd_write_en_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]       rd_data_q, rd_data_d;
  logic [XLEN-1:0]       busy_q, busy_d;

  assign bus.lsuReady = !fifo_full;
  assign fifo_push    = bus.lsuValid && !fifo_full;
  assign fifo_in      = '{rd: bus.lsuRd, data: bus.lsuData};
  assign fifo_pop     = !bus.aluValid && !fifo_empty;

  wb_fifo u_wb_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_entry (fifo_in),
    .pop        (fifo_pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (fifo_head),
    .count      (fifo_count)
  );

  // Write selection and registered write port.
  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (bus.aluValid) begin
      sel_valid = 1'b1;
      sel_rd    = bus.aluRd;
      sel_data  = bus.aluData;
    end else if (fifo_pop) begin
      sel_valid = 1'b1;
      sel_rd    = fifo_head.rd;
      sel_data  = fifo_head.data;
    end
    rd_write_en_d = sel_valid && (sel_rd != '0);
    rd_d          = rd_write_en_d ? sel_rd   : rd_q;
    rd_data_d     = rd_write_en_d ? sel_data : rd_data_q;
  end

  // Busy scoreboard: clear on drain of a FIFO entry, then set on a long
  // issue so that a same-cycle set overrides the clear.
  always_comb begin
    busy_d = busy_q;
    if (fifo_pop && (fifo_head.rd != '0)) begin
      busy_d[fifo_head.rd] = 1'b0;
    end
    if (bus.issueValid && bus.issueLong && (bus.issueRd != '0)) begin
      busy_d[bus.issueRd] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_write_en_q <= 1'b0;
      rd_q          <= '0;
      rd_data_q     <= '0;
      busy_q        <= '0;
    end else begin
      rd_write_en_q <= rd_write_en_d;
      rd_q          <= rd_d;
      rd_data_q     <= rd_data_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.rdWriteEn = rd_write_en_q;
  assign bus.rd        = rd_q;
  assign bus.rdData    = rd_data_q;
  assign bus.rs1Busy   = busy_q[bus.rs1] && (bus.rs1 != '0);
  assign bus.rs2Busy   = busy_q[bus.rs2] && (bus.rs2 != '0);

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_wb_arbiter;
  import core_pkg::*;

  logic clk;
  logic rst;

  wb_arbiter_if bus ();

  wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [36:0] exp_q[$];   // pending long-latency results {rd, data}
  logic [31:0] m_busy;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  int checks;
  int failures;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    exp_q.delete();
    m_busy = '0;
    m_we   = 1'b0;
    m_rd   = '0;
    m_data = '0;
  endtask

  // One rising edge of the model, using the inputs currently driven.
  task automatic m_edge();
    logic        w_valid;
    logic [4:0]  w_rd;
    logic [31:0] w_data;
    logic [36:0] e;
    logic        can_push;
    if (rst) begin
      m_reset();
      return;
    end
    can_push = (exp_q.size() < 2);
    w_valid  = 1'b0;
    w_rd     = '0;
    w_data   = '0;
    if (bus.aluValid) begin
      w_valid = 1'b1;
      w_rd    = bus.aluRd;
      w_data  = bus.aluData;
    end else if (exp_q.size() > 0) begin
      e       = exp_q.pop_front();
      w_valid = 1'b1;
      w_rd    = e[36:32];
      w_data  = e[31:0];
      if (w_rd != 0) m_busy[w_rd] = 1'b0;
    end
    if (bus.lsuValid && can_push) exp_q.push_back({bus.lsuRd, bus.lsuData});
    if (bus.issueValid && bus.issueLong && bus.issueRd != 0) m_busy[bus.issueRd] = 1'b1;
    m_we = w_valid && (w_rd != 0);
    if (m_we) begin
      m_rd   = w_rd;
      m_data = w_data;
    end
  endtask

  task automatic check_comb();
    check("lsuReady", 32'(bus.lsuReady), 32'(exp_q.size() < 2));
    check("rs1Busy", 32'(bus.rs1Busy), 32'(m_busy[bus.rs1] && bus.rs1 != 0));
    check("rs2Busy", 32'(bus.rs2Busy), 32'(m_busy[bus.rs2] && bus.rs2 != 0));
  endtask

  task automatic check_regs();
    check("rdWriteEn", 32'(bus.rdWriteEn), 32'(m_we));
    check("rd", 32'(bus.rd), 32'(m_rd));
    check("rdData", bus.rdData, m_data);
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge with inputs already driven; returns at the next one.
  task automatic step();
    assert (!(bus.issueValid && bus.issueLong && bus.issueRd != 0 && m_busy[bus.issueRd]))
      else $error("stimulus issued long op to busy rd %0d", bus.issueRd);
    #1;
    check_comb();
    @(posedge clk);
    m_edge();
    #1;
    check_regs();
    @(negedge clk);
  endtask

  task automatic set_idle();
    bus.aluValid   = 1'b0;
    bus.aluRd      = '0;
    bus.aluData    = '0;
    bus.lsuValid   = 1'b0;
    bus.lsuRd      = '0;
    bus.lsuData    = '0;
    bus.issueValid = 1'b0;
    bus.issueLong  = 1'b0;
    bus.issueRd    = '0;
  endtask

  task automatic drive_alu(input logic [4:0] r, input logic [31:0] d);
    bus.aluValid = 1'b1;
    bus.aluRd    = r;
    bus.aluData  = d;
  endtask

  task automatic drive_lsu(input logic [4:0] r, input logic [31:0] d);
    bus.lsuValid = 1'b1;
    bus.lsuRd    = r;
    bus.lsuData  = d;
  endtask

  task automatic drive_issue(input logic [4:0] r);
    bus.issueValid = 1'b1;
    bus.issueLong  = 1'b1;
    bus.issueRd    = r;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    set_idle();
    bus.rs1 = 5'd0;
    bus.rs2 = 5'd0;
    m_reset();
    @(negedge clk);

    // Reset state.
    repeat (2) step();
    rst = 1'b0;

    // ALU write appears one cycle later.
    drive_alu(5'd5, 32'h1234);
    step();
    check("alu_write_rd5", 32'(bus.rdWriteEn && bus.rd == 5'd5 && bus.rdData == 32'h1234), 32'd1);
    set_idle();
    step();

    // Long op on x7: busy until its result is written back.
    bus.rs1 = 5'd7;
    drive_issue(5'd7);
    step();
    set_idle();
    drive_lsu(5'd7, 32'hDEAD);
    step();
    set_idle();
    step();
    check("lsu_write_rd7", 32'(bus.rdWriteEn && bus.rd == 5'd7 && bus.rdData == 32'hDEAD), 32'd1);
    step();

    // ALU priority while the FIFO fills; backpressure at two entries.
    drive_alu(5'd1, 32'h1);  drive_lsu(5'd2, 32'hA); step();
    drive_alu(5'd3, 32'h3);  drive_lsu(5'd4, 32'hB); step();
    drive_alu(5'd5, 32'h5);  drive_lsu(5'd6, 32'hC); step();
    set_idle();
    repeat (3) step();

    // Destination x0 results never write but still drain.
    drive_lsu(5'd0, 32'hFFFF); step();
    set_idle(); drive_alu(5'd0, 32'h77); step();
    set_idle(); repeat (2) step();

    // Asynchronous reset with a full FIFO and x3 busy.
    bus.rs1 = 5'd3;
    drive_issue(5'd3); step();
    set_idle();
    drive_alu(5'd9, 32'h99); drive_lsu(5'd3, 32'h33); step();
    drive_alu(5'd9, 32'h98); drive_lsu(5'd8, 32'h88); step();
    set_idle();
    #2;
    rst = 1'b1;
    m_reset();
    #1;
    check("async_rst_we", 32'(bus.rdWriteEn), 32'd0);
    check("async_rst_rd", 32'(bus.rd), 32'd0);
    check("async_rst_data", bus.rdData, 32'd0);
    check("async_rst_ready", 32'(bus.lsuReady), 32'd1);
    check("async_rst_rs1busy", 32'(bus.rs1Busy), 32'd0);
    @(negedge clk);
    step();
    rst = 1'b0;
    drive_alu(5'd10, 32'hAB); step();
    set_idle(); step();

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      set_idle();
      if ($urandom_range(0, 99) < 35) drive_alu(5'($urandom_range(0, 31)), $urandom);
      if ($urandom_range(0, 99) < 45) drive_lsu(5'($urandom_range(0, 31)), $urandom);
      if ($urandom_range(0, 99) < 50) begin
        bus.issueValid = 1'b1;
        bus.issueRd    = 5'($urandom_range(0, 31));
        bus.issueLong  = ($urandom_range(0, 1) == 1) && !m_busy[bus.issueRd];
      end
      bus.rs1 = 5'($urandom_range(0, 31));
      bus.rs2 = ($urandom_range(0, 1) == 1) ? bus.issueRd : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        m_reset();
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
